ecc_90_enc_fault_detc: RTL
==========================

// Module: ecc_90_enc_fault_detc
// PURPOSE
//  Write-side partner of the FIFO SEC-DED read path. Encodes 90-bit words into
//  8 check bits with two lockstep encoders. The encoder outputs are compared
//  per word, and a mismatch raises a fault flag.
//  One registered valid/ready stage with a 2-entry skid buffer sits in front of
//  the FIFO RAM write port.
//  A one-shot error injector corrupts a chosen codeword, so the downstream
//  decoder's sbit_err/dbit_err paths can be exercised in silicon.
// PARAMETERS
//  DATA_WIDTH    90  data bits per word
//  PARITY_WIDTH  8   check bits; 7 Hamming bits + 1 overall parity
//  CNT_WIDTH     8   width of the saturating fault counter
// PORTS
//  clk                in   1    clock
//  rst_n              in   1    reset, asynchronous assert, active-low
//  ecc_fault_detc_en  in   1    enables the lockstep compare and fault reporting
//  in_valid           in   1    input word valid
//  in_ready           out  1    block can accept a word
//  data_in            in   90   raw write data
//  out_valid          out  1    encoded word valid
//  out_ready          in   1    downstream accepts the word
//  data_out           out  90   data, after any injection
//  parity_out         out  8    check bits, after any injection
//  ecc_fault          out  1    sideband flag, qualified by out_valid: lockstep mismatch on this word
//  fault_sticky       out  1    set by any reported fault; cleared only by fault_clr or reset
//  fault_cnt          out  CNT_WIDTH  saturating count of reported faults
//  fault_clr          in   1    one-cycle pulse; clears fault_sticky and fault_cnt
//  inj_arm            in   1    one-cycle pulse; arms the injector
//  inj_mode           in   2    00 none; 01 single-bit flip; 10 double-bit flip; 11 reserved (= none)
//  inj_pos            in   7    codeword bit index: 0..89 data, 90..97 parity
//  inj_done           out  1    one-cycle pulse when the armed injection is consumed
// BEHAVIOUR
//  Reset values: every register is 0. out_valid=0, ecc_fault=0, fault_sticky=0,
//   fault_cnt=0, inj_done=0, injector disarmed. in_ready=1 once rst_n is high.
//  An rst_n assertion mid-stream drops every buffered word.
//  Encoding:
//   - Two instances of ecc_90_cal are used; only their parity_out port is used.
//   - In both instances parity_in is tied to 0 and bypass is tied to 0.
//   - parity_out comes from instance 0.
//   - The codeword matches what the read-side ecc_90_cal decodes with zero syndrome.
//  Handshake:
//   - A word is accepted when in_valid & in_ready.
//   - A word is transferred when out_valid & out_ready.
//   - data_out/parity_out/ecc_fault are held stable while out_valid & ~out_ready.
//  Latency: an accepted word appears on out_valid on the next cycle, if the
//   output register is free or being drained.
//  Skid buffer:
//   - in_ready is registered and equals ~skid_valid.
//   - A word accepted while the output is stalled goes into the skid entry.
//   - When the output drains, the skid entry moves to the output register.
//   - Words leave in order; no word is lost or duplicated.
//   - Full throughput: 1 word/cycle while out_ready=1.
//  Lockstep compare, evaluated at acceptance:
//   - mis = (par0 != par1) & ecc_fault_detc_en.
//   - mis is stored with the word and presented as ecc_fault.
//   - The word is still forwarded with par0.
//  Fault status, updated the cycle after a mis word is accepted:
//   - fault_sticky <= 1.
//   - fault_cnt increments and saturates at 2^CNT_WIDTH-1.
//   - fault_clr in the same cycle as the update: the fault wins, so sticky=1 and cnt=1.
//   - fault_clr alone: sticky=0, cnt=0.
//  Injector:
//   - inj_arm captures inj_mode and inj_pos and sets armed. A re-arm overwrites the captured values.
//   - The next accepted word is corrupted:
//     - mode 01 flips codeword bit inj_pos.
//     - mode 10 flips bits inj_pos and (inj_pos+1) mod 98.
//   - The flip is applied after parity generation and after the compare.
//   - Index >= 98 flips nothing.
//   - After the corrupted word: armed clears and inj_done pulses once.
//   - If inj_arm coincides with acceptance: the current word uses the old state, and the new arm takes effect for the next word.
//  No combinational path from out_ready to in_ready.
// TESTING
//  1. Reset mid-stream: rst_n=0 while 2 words are buffered.
//     -> out_valid=0 and fault_cnt=0 at once; in_ready=1 after release.
//  2. Backpressure: out_ready=0, drive 4 words A..D.
//     -> in_ready=0 after A and B are accepted.
//     -> out_ready=1 gives A,B,C,D in order with no gaps.
//  3. Codeword check: data_in=90'h1, then all-ones, then random.
//     -> Each output into a read-side ecc_90_cal gives sbit_err=0, dbit_err=0, unchanged data.
//  4. Injection:
//     - arm mode 01, pos 5 -> data_out[5] inverted; decoder sbit_err=1 and corrects; inj_done pulses once.
//     - mode 10, pos 97 -> bits 97 and 0 flipped; decoder dbit_err=1.
//  5. Lockstep fault: force instance-1 parity bit 3, with detc_en=1.
//     -> ecc_fault=1 on that word; sticky=1; cnt=1.
//     - With detc_en=0 -> ecc_fault=0 and cnt unchanged.
//  6. Saturation and clear: CNT_WIDTH=2, 5 forced faults.
//     -> fault_cnt=3.
//     - fault_clr in the same cycle as a 6th fault -> fault_cnt=1, fault_sticky=1.

Source files
------------

// File: rtl/ecc_90_enc_fault_detc.sv
// ecc_90_cal: SEC-DED (extended Hamming) calculator for 90-bit words.
//   Encode side: parity_out carries the 8 check bits of data_in
//   (bits [6:0] Hamming, bit [7] overall parity over data and Hamming bits).
//   Decode side: compares against parity_in, flags single/double errors and
//   corrects a single flipped data bit on data_out. bypass disables detection.
// Ports:
//   data_in    [89:0] word to encode / received data
//   parity_in  [7:0]  received check bits (tie to 0 when only encoding)
//   bypass            1 = no detection or correction
//   data_out   [89:0] corrected data
//   parity_out [7:0]  freshly generated check bits of data_in
//   sbit_err          single-bit error detected (and corrected if in data)
//   dbit_err          uncorrectable double-bit error detected
//
// ecc_90_enc_fault_detc: write-side encoder with lockstep fault detection.
//   Two ecc_90_cal instances encode each word; a disagreement is reported as
//   ecc_fault alongside the word. One output register plus a skid entry form
//   a valid/ready stage. A one-shot injector can corrupt one codeword so the
//   read-side decoder error paths can be exercised.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   ecc_fault_detc_en              enables lockstep compare / fault reporting
//   in_valid, in_ready, data_in    input handshake and raw data
//   out_valid, out_ready           output handshake
//   data_out, parity_out           codeword, after any injection
//   ecc_fault                      lockstep mismatch for the presented word
//   fault_sticky, fault_cnt        fault status, cleared by fault_clr
//   fault_clr                      clear pulse for sticky flag and counter
//   inj_arm, inj_mode, inj_pos     injector arm pulse and settings
//   inj_done                       pulse when an armed injection is consumed

module ecc_90_cal (
  input  logic [89:0] data_in,
  input  logic [7:0]  parity_in,
  input  logic        bypass,
  output logic [89:0] data_out,
  output logic [7:0]  parity_out,
  output logic        sbit_err,
  output logic        dbit_err
);
  localparam int DW   = 90;
  localparam int HW   = 7;
  localparam int NPOS = DW + HW;

  // Data bits occupy the non-power-of-two positions 1..NPOS of the Hamming
  // codeword, in ascending order. Hamming bit i covers every position whose
  // index has bit i set.
  function automatic logic [DW-1:0] cover_mask(input int bit_idx);
    logic [DW-1:0] m;
    int k;
    m = '0;
    k = 0;
    for (int p = 1; p <= NPOS; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (((p >> bit_idx) & 1) != 0) m = m | (DW'(1) << k);
        k++;
      end
    end
    return m;
  endfunction

  function automatic logic [HW-1:0] data_pos(input int idx);
    logic [HW-1:0] r;
    int k;
    r = '0;
    k = 0;
    for (int p = 1; p <= NPOS; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (k == idx) r = HW'(p);
        k++;
      end
    end
    return r;
  endfunction

  logic [HW-1:0] ham;
  logic [HW-1:0] syn;
  logic          overall;

  for (genvar i = 0; i < HW; i++) begin : g_ham
    localparam logic [DW-1:0] MASK = cover_mask(i);
    assign ham[i] = ^(data_in & MASK);
  end

  assign parity_out = {(^data_in) ^ (^ham), ham};

  assign syn      = ham ^ parity_in[HW-1:0];
  assign overall  = (^data_in) ^ (^parity_in);
  // Odd overall parity means one flipped bit; even parity with a non-zero
  // syndrome means two.
  assign sbit_err = ~bypass & overall;
  assign dbit_err = ~bypass & ~overall & (syn != '0);

  for (genvar j = 0; j < DW; j++) begin : g_fix
    localparam logic [HW-1:0] POS = data_pos(j);
    assign data_out[j] = data_in[j] ^ (sbit_err & (syn == POS));
  end

endmodule

module ecc_90_enc_fault_detc #(
  parameter int DATA_WIDTH   = 90,
  parameter int PARITY_WIDTH = 8,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ecc_fault_detc_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [PARITY_WIDTH-1:0] parity_out,
  output logic                    ecc_fault,
  output logic                    fault_sticky,
  output logic [CNT_WIDTH-1:0]    fault_cnt,
  input  logic                    fault_clr,
  input  logic                    inj_arm,
  input  logic [1:0]              inj_mode,
  input  logic [6:0]              inj_pos,
  output logic                    inj_done
);
  localparam int CW_WIDTH = DATA_WIDTH + PARITY_WIDTH;

  logic [PARITY_WIDTH-1:0] par0;
  logic [PARITY_WIDTH-1:0] par1;
  logic                    mis;
  logic                    accept;

  logic [DATA_WIDTH-1:0]   enc0_unused_data;
  logic [DATA_WIDTH-1:0]   enc1_unused_data;
  logic                    enc0_unused_sbit;
  logic                    enc0_unused_dbit;
  logic                    enc1_unused_sbit;
  logic                    enc1_unused_dbit;

  logic                    skid_valid;
  logic [DATA_WIDTH-1:0]   skid_data;
  logic [PARITY_WIDTH-1:0] skid_par;
  logic                    skid_fault;

  logic                    inj_armed;
  logic [1:0]              inj_mode_q;
  logic [6:0]              inj_pos_q;
  logic [CW_WIDTH-1:0]     flip_a;
  logic [CW_WIDTH-1:0]     flip_b;
  logic [CW_WIDTH-1:0]     flip_mask;
  logic [CW_WIDTH-1:0]     code_new;
  logic [DATA_WIDTH-1:0]   new_data;
  logic [PARITY_WIDTH-1:0] new_par;

  ecc_90_cal u_enc0 (
    .data_in    (data_in),
    .parity_in  (8'h00),
    .bypass     (1'b0),
    .data_out   (enc0_unused_data),
    .parity_out (par0),
    .sbit_err   (enc0_unused_sbit),
    .dbit_err   (enc0_unused_dbit)
  );

  ecc_90_cal u_enc1 (
    .data_in    (data_in),
    .parity_in  (8'h00),
    .bypass     (1'b0),
    .data_out   (enc1_unused_data),
    .parity_out (par1),
    .sbit_err   (enc1_unused_sbit),
    .dbit_err   (enc1_unused_dbit)
  );

  // in_ready comes straight from a register, so out_ready never reaches it
  // combinationally.
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign mis      = (par0 != par1) & ecc_fault_detc_en;

  // Corruption lands after encoding and after the lockstep compare, so the
  // injected word never registers as a lockstep fault. The second flip of a
  // double-bit injection wraps from the last parity bit to data bit 0.
  always_comb begin
    flip_a = '0;
    flip_b = '0;
    if (inj_pos_q < 7'(CW_WIDTH)) begin
      flip_a = CW_WIDTH'(1) << inj_pos_q;
      if (inj_pos_q == 7'(CW_WIDTH - 1)) flip_b = CW_WIDTH'(1);
      else                               flip_b = CW_WIDTH'(1) << (inj_pos_q + 7'd1);
    end
    flip_mask = '0;
    if (inj_armed) begin
      case (inj_mode_q)
        2'b01:   flip_mask = flip_a;
        2'b10:   flip_mask = flip_a | flip_b;
        default: flip_mask = '0;
      endcase
    end
  end

  assign code_new = {par0, data_in} ^ flip_mask;
  assign new_data = code_new[DATA_WIDTH-1:0];
  assign new_par  = code_new[CW_WIDTH-1:DATA_WIDTH];

  // Output register refills from the skid entry first to keep words in
  // order; the skid entry only captures while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      data_out   <= '0;
      parity_out <= '0;
      ecc_fault  <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_par   <= '0;
      skid_fault <= 1'b0;
    end else begin
      if (!out_valid || out_ready) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          data_out   <= skid_data;
          parity_out <= skid_par;
          ecc_fault  <= skid_fault;
          skid_valid <= 1'b0;
        end else if (accept) begin
          out_valid  <= 1'b1;
          data_out   <= new_data;
          parity_out <= new_par;
          ecc_fault  <= mis;
        end else begin
          out_valid  <= 1'b0;
        end
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_data  <= new_data;
        skid_par   <= new_par;
        skid_fault <= mis;
      end
    end
  end

  // A fault arriving with fault_clr restarts the count at one rather than
  // being lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_sticky <= 1'b0;
      fault_cnt    <= '0;
    end else if (accept && mis) begin
      fault_sticky <= 1'b1;
      if (fault_clr)                             fault_cnt <= CNT_WIDTH'(1);
      else if (fault_cnt != {CNT_WIDTH{1'b1}})   fault_cnt <= fault_cnt + CNT_WIDTH'(1);
    end else if (fault_clr) begin
      fault_sticky <= 1'b0;
      fault_cnt    <= '0;
    end
  end

  // An arm in the same cycle as an acceptance applies to the following word;
  // the current word consumes whatever was armed before.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_armed  <= 1'b0;
      inj_mode_q <= 2'b00;
      inj_pos_q  <= '0;
      inj_done   <= 1'b0;
    end else begin
      inj_done <= accept & inj_armed;
      if (inj_arm) begin
        inj_armed  <= 1'b1;
        inj_mode_q <= inj_mode;
        inj_pos_q  <= inj_pos;
      end else if (accept) begin
        inj_armed  <= 1'b0;
      end
    end
  end

endmodule
